// File: rtl/iiitb_apb_pkg.sv
// Shared definitions for the iiitb APB bridge and its completers.
package iiitb_apb_pkg;

  localparam int unsigned APB_ADDR_W    = 9;
  localparam int unsigned APB_DATA_W    = 8;
  localparam int unsigned SLAVE_SEL_BIT = 8;
  localparam int unsigned WAIT_CNT_W    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/iiitb_apb_slave_mem.sv
// Register storage with per-location written flags; flags clear on reset, data does not.
module iiitb_apb_slave_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              rd_written_c
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else if (wr_en) begin
      written[wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    rd_data_c    = mem[rd_idx];
    rd_written_c = written[rd_idx];
  end

endmodule

// File: rtl/iiitb_apb_slave.sv
// APB completer: setup latch, programmable wait states, registered response and error reporting.
module iiitb_apb_slave
  import iiitb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W           = SLAVE_SEL_BIT,
  parameter int unsigned DATA_W           = APB_DATA_W,
  parameter int unsigned DEPTH            = 64,
  parameter int unsigned WAIT_STATES      = 1,
  parameter bit          ERR_ON_UNWRITTEN = 1'b1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;

  logic [ADDR_W-1:0]     resp_addr;
  logic                  resp_write;
  logic                  in_range;
  logic                  resp_err;
  logic [DATA_W-1:0]     resp_data;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_written;

  // With zero wait states the response is built in the setup cycle, so look at the live bus then.
  always_comb begin
    resp_addr  = (state == IDLE) ? PADDR  : addr_q;
    resp_write = (state == IDLE) ? PWRITE : write_q;
    in_range   = 32'(resp_addr) < DEPTH;
    resp_err   = !in_range || (!resp_write && !mem_written && ERR_ON_UNWRITTEN);
    resp_data  = (!resp_write && in_range && mem_written) ? mem_rdata : '0;
    mem_we     = (state == ACCESS) && PSEL && PENABLE && PREADY && write_q && in_range;
  end

  iiitb_apb_slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk          (PCLK),
    .rst          (PRESET),
    .wr_en        (mem_we),
    .wr_idx       (addr_q[IDX_W-1:0]),
    .wr_data      (wdata_q),
    .rd_idx       (resp_addr[IDX_W-1:0]),
    .rd_data_c    (mem_rdata),
    .rd_written_c (mem_written)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt     <= WAIT_CNT_W'(WAIT_STATES);
            state   <= ACCESS;
            if (WAIT_STATES == 0) begin
              PREADY  <= 1'b1;
              PSLVERR <= resp_err;
              PRDATA  <= resp_data;
            end
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else if (PREADY) begin
            if (PENABLE) begin
              state   <= IDLE;
              PREADY  <= 1'b0;
              PSLVERR <= 1'b0;
              PRDATA  <= '0;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - WAIT_CNT_W'(1);
            if (cnt == WAIT_CNT_W'(1)) begin
              PREADY  <= 1'b1;
              PSLVERR <= resp_err;
              PRDATA  <= resp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_apb_slave.sv
// Three completer builds (WS=1/ERR=1, WS=1/ERR=0, WS=0/ERR=1) checked by a scoreboard against a register model.
module tb_iiitb_apb_slave;

  localparam int NDUT = 3;

  typedef struct {
    int         k;
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       psel    [NDUT];
  logic       penable [NDUT];
  logic       pwrite  [NDUT];
  logic [7:0] paddr   [NDUT];
  logic [7:0] pwdata  [NDUT];
  logic [7:0] prdata  [NDUT];
  logic       pready  [NDUT];
  logic       pslverr [NDUT];

  exp_t       exp_q[$];
  logic [7:0] mem_m [NDUT][64];
  bit         wr_m  [NDUT][64];
  int         n_cmp;
  int         n_bad;

  iiitb_apb_slave #(.WAIT_STATES(1), .ERR_ON_UNWRITTEN(1'b1)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  iiitb_apb_slave #(.WAIT_STATES(1), .ERR_ON_UNWRITTEN(1'b0)) dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  iiitb_apb_slave #(.WAIT_STATES(0), .ERR_ON_UNWRITTEN(1'b1)) dut2 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ws_of(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit err_of(int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected completion for a transfer issued now, from the register model.
  function automatic exp_t model_resp(int k, bit w, logic [7:0] a);
    exp_t e;
    e.k    = k;
    e.cyc  = ws_of(k) + 1;
    e.err  = 1'b0;
    e.data = 8'h00;
    if (int'(a) >= 64) begin
      e.err = 1'b1;
    end else if (!w) begin
      if (wr_m[k][int'(a)]) e.data = mem_m[k][int'(a)];
      else e.err = err_of(k);
    end
    return e;
  endfunction

  task automatic monitor();
    int   acc [NDUT];
    exp_t e;
    foreach (acc[i]) acc[i] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rst || !psel[k] || !penable[k]) acc[k] = 0;
        else acc[k]++;
        if (pready[k]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_pready_dut%0d", k), 32'(pready[k]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("resp_dut_id_dut%0d", k), 32'(k), 32'(e.k));
            check($sformatf("pslverr_dut%0d", k), 32'(pslverr[k]), 32'(e.err));
            check($sformatf("prdata_dut%0d", k), 32'(prdata[k]), 32'(e.data));
            check($sformatf("access_cycles_dut%0d", k), 32'(acc[k]), 32'(e.cyc));
          end
        end else if (pslverr[k] || prdata[k] != 8'h00) begin
          check($sformatf("idle_outputs_dut%0d", k), {23'd0, pslverr[k], prdata[k]}, 32'd0);
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < NDUT; k++) begin
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(int k, bit w, logic [7:0] a, logic [7:0] d);
    int cyc;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = w; paddr[k] = a; pwdata[k] = d;
    exp_q.push_back(model_resp(k, w, a));
    @(posedge clk); #1;
    penable[k] = 1'b1;
    paddr[k]   = 8'($urandom);
    pwdata[k]  = 8'($urandom);
    cyc = 1;
    while (!pready[k] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!pready[k]) begin
      check($sformatf("xfer_timeout_dut%0d", k), 32'(pready[k]), 32'd1);
    end else begin
      @(posedge clk); #1;
      if (w && int'(a) < 64) begin
        mem_m[k][int'(a)] = d;
        wr_m[k][int'(a)]  = 1'b1;
      end
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  // Setup, then PSEL drops during the first wait-state cycle.
  task automatic abort_xfer(int k, bit w, logic [7:0] a, logic [7:0] d);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = w; paddr[k] = a; pwdata[k] = d;
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b1;
    @(posedge clk); #1;
    penable[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 64; i++) wr_m[k][i] = 1'b0;
  endtask

  task automatic check_outputs_zero(string tag);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_pready_dut%0d", tag, k), 32'(pready[k]), 32'd0);
      check($sformatf("%s_pslverr_dut%0d", tag, k), 32'(pslverr[k]), 32'd0);
      check($sformatf("%s_prdata_dut%0d", tag, k), 32'(prdata[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    bit         w;
    int         k;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h00; pwdata[i] = 8'h00;
      for (int j = 0; j < 64; j++) begin
        mem_m[i][j] = 8'h00;
        wr_m[i][j]  = 1'b0;
      end
    end
    fork
      monitor();
    join_none
    #2;
    do_reset();
    check_outputs_zero("reset");

    xfer(0, 1'b1, 8'h03, 8'h06);
    xfer(0, 1'b0, 8'h03, 8'h00);
    idle(2);

    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 8'(i), 8'(2 * i));
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 8'(i), 8'h00);
    idle(1);

    xfer(0, 1'b0, 8'h2D, 8'h00);
    xfer(1, 1'b0, 8'h2D, 8'h00);
    idle(1);

    xfer(0, 1'b1, 8'h4E, 8'h09);
    xfer(0, 1'b0, 8'h0E, 8'h00);
    xfer(0, 1'b0, 8'h4E, 8'h00);
    idle(1);

    abort_xfer(0, 1'b1, 8'h10, 8'h23);
    idle(1);
    xfer(0, 1'b0, 8'h10, 8'h00);
    abort_xfer(1, 1'b1, 8'h10, 8'h23);
    idle(1);
    xfer(1, 1'b0, 8'h10, 8'h00);
    idle(1);

    // Reset lands in the wait state of a write to an already-written location.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h03; pwdata[0] = 8'h55;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #2;
    do_reset();
    check_outputs_zero("midreset");
    xfer(0, 1'b0, 8'h03, 8'h00);
    xfer(0, 1'b0, 8'h00, 8'h00);
    idle(1);

    xfer(2, 1'b1, 8'h05, 8'hA5);
    xfer(2, 1'b0, 8'h05, 8'h00);
    xfer(2, 1'b0, 8'h06, 8'h00);
    xfer(2, 1'b1, 8'h40, 8'h11);
    idle(1);

    for (int n = 0; n < 180; n++) begin
      k = int'($urandom_range(0, NDUT - 1));
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (k != 2 && $urandom_range(0, 9) == 0) begin
        abort_xfer(k, w, a, d);
      end else begin
        xfer(k, w, a, d);
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iiitb_apb_slave.md
Name: iiitb_apb_slave

Overview:
APB2/APB3 completer that terminates transfers issued by the iiitb_apb bridge on one slave select. It has a DEPTH x DATA_W register memory with per-location "written" flags and a programmable number of wait states driven on PREADY. PSLVERR is raised for out-of-range addresses and for reads of never-written locations. Two instances sit behind the bridge, one per PADDR[8] decode.

Parameters:
ADDR_W, 8, width of PADDR seen by this slave (the bridge strips the select bit)
DATA_W, 8, width of PWDATA/PRDATA
DEPTH, 64, number of implemented locations; addresses >= DEPTH are errors
WAIT_STATES, 1, PREADY-low cycles inserted in every access phase (0..15)
ERR_ON_UNWRITTEN, 1, 1 = a read of a location never written since reset returns PSLVERR

Ports:
PCLK  in  1  clock, all state on rising edge
PRESET  in  1  reset, asynchronous, active-high
PSEL  in  1  slave select from bridge
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  word address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data, valid only while PREADY=1 on a read
PREADY  out  1  transfer-complete indicator, registered
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset (async, PRESET=1): state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0; all written flags cleared. Memory data is not reset. Any transfer in flight is abandoned and no write happens.
- States: IDLE, ACCESS.
- IDLE:
  - PSEL=1 & PENABLE=0 (setup) latches PADDR, PWRITE, PWDATA; wait counter loads WAIT_STATES; next state ACCESS.
  - If WAIT_STATES=0, PREADY is set at the same edge.
  - PENABLE=1 without a preceding setup is ignored and stays in IDLE.
- ACCESS:
  - Counter > 0: decrement; when it reaches 0, set PREADY at that edge. PREADY is therefore high in access cycle WAIT_STATES+1.
  - Completion edge: PSEL=1 & PENABLE=1 & PREADY=1. Commit the write if it is not an error, set written[addr]. Clear PREADY/PSLVERR/PRDATA; next state IDLE.
  - PSEL=0 at any point before completion: abort, nothing written, outputs cleared, go to IDLE.
- Latency: setup plus WAIT_STATES+1 access cycles, i.e. WAIT_STATES+2 PCLK cycles per transfer. Back-to-back transfers: a setup in the cycle after completion is accepted from IDLE.
- Response values are computed from the latched address and registered together with PREADY:
  - addr >= DEPTH: PSLVERR=1, PRDATA=0, write suppressed.
  - Read with written[addr]=0 and ERR_ON_UNWRITTEN=1: PSLVERR=1, PRDATA=0.
  - Read with written[addr]=0 and ERR_ON_UNWRITTEN=0: PSLVERR=0, PRDATA=0.
  - Valid read: PRDATA=mem[addr], PSLVERR=0.
  - Valid write: PSLVERR=0, PRDATA=0.
- Write followed immediately by a read of the same address returns the new data; the write has committed before the read setup.
- PADDR/PWDATA changes during ACCESS are ignored; only setup-cycle values are used.
- PRDATA and PSLVERR are forced to 0 whenever PREADY=0.

Decomposition:
- Package iiitb_apb_pkg holds:
  - state encoding (IDLE, ACCESS)
  - APB_ADDR_W=9, APB_DATA_W=8
  - SLAVE_SEL_BIT=8
  - wait-counter width 4
- Sub-module iiitb_apb_slave_mem holds the storage array, written-flag vector, synchronous write port, combinational read port, and async clear of the flags.
- Top-level iiitb_apb_slave holds the FSM, wait counter, latches and response registers.

Test Plan:
- Reset, then write addr 0x03 data 0x06 with WAIT_STATES=1 -> PREADY low in access cycle 1, high in cycle 2, PSLVERR=0; a subsequent read of 0x03 returns PRDATA=0x06.
- Write 0x00..0x07 with data 2*i, then read 0x00..0x07 back-to-back -> each read returns 2*i, PSLVERR=0, each transfer takes 3 cycles.
- Read addr 0x2D never written (ERR_ON_UNWRITTEN=1) -> PREADY=1, PSLVERR=1, PRDATA=0x00; rerun with ERR_ON_UNWRITTEN=0 -> PSLVERR=0, PRDATA=0x00.
- Write addr 0x4E (>= DEPTH=64) data 0x09 -> PSLVERR=1; no flag or memory change, confirmed by reading 0x0E, which is still unwritten.
- Drop PSEL during a wait state of a write to 0x10 data 0x23, and separately assert PRESET mid-access -> PREADY stays 0, next state IDLE; a read of 0x10 reports unwritten. After reset all outputs are 0 and all previously written flags are cleared.
- WAIT_STATES=0 build: write then read 0x05 data 0xA5 -> PREADY high in the first access cycle, 2-cycle transfers, PRDATA=0xA5.
